// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: TAP state encodings, opcodes and the shared next-state function
package jtag_tap_pkg;
  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SHIFT_DR = 4'h2,
    EXIT1_DR = 4'h1,
    PAUSE_DR = 4'h3,
    EXIT2_DR = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SHIFT_IR = 4'hA,
    EXIT1_IR = 4'h9,
    PAUSE_IR = 4'hB,
    EXIT2_IR = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;
  localparam logic [3:0] OP_EXTEST         = 4'b0000;
  localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'b0001;
  localparam logic [3:0] OP_IDCODE         = 4'b0010;
  localparam logic [3:0] OP_DEBUG          = 4'b1000;
  localparam logic [3:0] OP_MBIST          = 4'b1001;
  localparam logic [3:0] OP_BYPASS         = 4'b1111;
  localparam logic [3:0] IR_CAPTURE        = 4'b0101;
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TLR:      return tms ? TLR      : RTI;
      RTI:      return tms ? SEL_DR   : RTI;
      SEL_DR:   return tms ? SEL_IR   : CAP_DR;
      CAP_DR:   return tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: return tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: return tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: return tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   return tms ? SEL_DR   : RTI;
      SEL_IR:   return tms ? TLR      : CAP_IR;
      CAP_IR:   return tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: return tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: return tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: return tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   return tms ? SEL_DR   : RTI;
      default:  return TLR;
    endcase
  endfunction
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state IEEE 1149.1 TAP controller
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trstn,
  input  logic       tms,
  output tap_state_e state
);
  tap_state_e nxt;
  // next state follows tms through the standard TAP graph
  always_comb nxt = tap_next(state, tms);
  // state register, forced to Test-Logic-Reset by trstn
  always_ff @(posedge tck or negedge trstn)
    if (!trstn) state <= TLR;
    else state <= nxt;
endmodule

// File: rtl/jtag_tap_slave.sv
// jtag_tap_slave: JTAG TAP with IR, IDCODE/BYPASS data registers and debug-unit hookup
module jtag_tap_slave
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h149511c3,
  parameter int          IR_LENGTH    = 4
) (
  input  logic tck_pad_i,
  input  logic trstn_pad_i,
  input  logic tms_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad_o,
  output logic tdo_padoe_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic capture_dr_o,
  output logic debug_select_o,
  input  logic debug_tdo_i,
  output logic tdi_o
);
  tap_state_e state;
  logic [IR_LENGTH-1:0] ir, ir_shift;
  logic [31:0] id_shift;
  logic bypass, sel_idcode, tdo_next;
  jtag_tap_fsm u_fsm (
    .tck   (tck_pad_i),
    .trstn (trstn_pad_i),
    .tms   (tms_pad_i),
    .state (state)
  );
  assign shift_dr_o     = state == SHIFT_DR;
  assign pause_dr_o     = state == PAUSE_DR;
  assign update_dr_o    = state == UPD_DR;
  assign capture_dr_o   = state == CAP_DR;
  assign debug_select_o = ir == IR_LENGTH'(OP_DEBUG);
  assign sel_idcode     = ir == IR_LENGTH'(OP_IDCODE);
  assign tdi_o          = tdi_pad_i;
  // instruction path: capture/shift the IR chain, latch it on Update-IR, fall back to IDCODE on TLR entry
  always_ff @(posedge tck_pad_i or negedge trstn_pad_i)
    if (!trstn_pad_i) begin
      ir_shift <= '0;
      ir       <= IR_LENGTH'(OP_IDCODE);
    end else begin
      ir_shift <= state == CAP_IR ? IR_LENGTH'(IR_CAPTURE) :
                  state == SHIFT_IR ? {tdi_pad_i, ir_shift[IR_LENGTH-1:1]} : ir_shift;
      ir       <= tap_next(state, tms_pad_i) == TLR ? IR_LENGTH'(OP_IDCODE) :
                  state == UPD_IR ? ir_shift : ir;
    end
  // data path: 32-bit ID chain when IDCODE is selected, single bypass bit otherwise
  always_ff @(posedge tck_pad_i or negedge trstn_pad_i)
    if (!trstn_pad_i) begin
      id_shift <= '0;
      bypass   <= 1'b0;
    end else begin
      id_shift <= !sel_idcode ? id_shift :
                  state == CAP_DR ? IDCODE_VALUE :
                  state == SHIFT_DR ? {tdi_pad_i, id_shift[31:1]} : id_shift;
      bypass   <= state == CAP_DR ? 1'b0 : state == SHIFT_DR ? tdi_pad_i : bypass;
    end
  // serial return source for the current shift state
  always_comb
    tdo_next = state == SHIFT_IR ? ir_shift[0] :
               state != SHIFT_DR ? 1'b0 :
               sel_idcode ? id_shift[0] :
               debug_select_o ? debug_tdo_i : bypass;
  // tdo and its enable launch on the falling edge so the host samples them on the next rising edge
  always_ff @(negedge tck_pad_i or negedge trstn_pad_i)
    if (!trstn_pad_i) begin
      tdo_pad_o   <= 1'b0;
      tdo_padoe_o <= 1'b0;
    end else begin
      tdo_pad_o   <= tdo_next;
      tdo_padoe_o <= state == SHIFT_IR || state == SHIFT_DR;
    end
endmodule

// File: tb/tb_jtag_tap_slave.sv
// tb_jtag_tap_slave: directed TAP sequences with a tdo scoreboard
module tb_jtag_tap_slave;
  localparam logic [31:0] ID = 32'h149511c3;
  localparam logic [63:0] ONES = '1;
  logic tck = 1'b0, trstn = 1'b1, tms = 1'b1, tdi = 1'b0, dbg_tdo = 1'b0;
  logic tdo, tdo_oe, shift_dr, pause_dr, update_dr, capture_dr, dsel, tdi_fwd;
  int errors = 0, checks = 0;
  logic  exp_q[$];
  string nm_q[$];
  int    idx_q[$];
  jtag_tap_slave dut (
    .tck_pad_i      (tck),
    .trstn_pad_i    (trstn),
    .tms_pad_i      (tms),
    .tdi_pad_i      (tdi),
    .tdo_pad_o      (tdo),
    .tdo_padoe_o    (tdo_oe),
    .shift_dr_o     (shift_dr),
    .pause_dr_o     (pause_dr),
    .update_dr_o    (update_dr),
    .capture_dr_o   (capture_dr),
    .debug_select_o (dsel),
    .debug_tdo_i    (dbg_tdo),
    .tdi_o          (tdi_fwd)
  );
  always #5 tck = ~tck;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #2;
  endtask
  task automatic expect_bit(input string name, input int i, input logic b);
    exp_q.push_back(b);
    nm_q.push_back(name);
    idx_q.push_back(i);
  endtask
  task automatic shift_dr_seq(input string name, input int n, input logic [63:0] din,
                              input logic [63:0] dexp, input logic [63:0] dbg);
    step(1, 0);
    step(0, 0);
    chk({name, "_capture"}, capture_dr, 1);
    step(0, 0);
    for (int i = 0; i < n; i++) begin
      chk({name, "_shift_dr"}, shift_dr, 1);
      dbg_tdo = dbg[i];
      expect_bit(name, i, dexp[i]);
      step(i == n - 1, din[i]);
    end
    step(1, 0);
    chk({name, "_update"}, update_dr, 1);
    step(0, 0);
  endtask
  task automatic shift_ir_seq(input string name, input logic [3:0] din);
    logic [3:0] cap;
    cap = 4'b0101;
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 4; i++) begin
      expect_bit(name, i, cap[i]);
      step(i == 3, din[i]);
    end
    step(1, 0);
    step(0, 0);
  endtask
  // monitor: every falling edge with tdo enabled presents one bit to the scoreboard
  initial begin
    logic  e;
    string n;
    int    k;
    forever begin
      @(negedge tck);
      #2;
      if (tdo_oe) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tdo: got %b expected no shift", tdo);
        end else begin
          e = exp_q.pop_front();
          n = nm_q.pop_front();
          k = idx_q.pop_front();
          if (tdo !== e) begin
            errors++;
            $display("FAIL %s bit %0d: got %b expected %b", n, k, tdo, e);
          end
        end
      end
    end
  end
  initial begin
    #3 trstn = 1'b0;
    #3;
    chk("reset_decodes", {shift_dr, pause_dr, update_dr, capture_dr}, 0);
    chk("reset_oe", tdo_oe, 0);
    chk("reset_tdo", tdo, 0);
    chk("reset_dsel", dsel, 0);
    @(posedge tck);
    #2 trstn = 1'b1;
    step(0, 0);
    shift_dr_seq("idcode_reset", 32, 64'h0, {32'h0, ID}, ONES);
    tdi = 1'b1;
    #1 chk("tdi_fwd_1", tdi_fwd, 1);
    tdi = 1'b0;
    #1 chk("tdi_fwd_0", tdi_fwd, 0);
    shift_ir_seq("ir_bypass", 4'b1111);
    chk("bypass_dsel", dsel, 0);
    shift_dr_seq("bypass", 4, 64'hD, 64'hA, ONES);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    expect_bit("tlr_abort", 0, 1'b0);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("tlr_decodes", {shift_dr, pause_dr, update_dr, capture_dr}, 0);
    @(negedge tck);
    #3 chk("tlr_oe", tdo_oe, 0);
    step(0, 0);
    chk("tlr_dsel", dsel, 0);
    shift_dr_seq("idcode_after_tlr", 32, 64'h0, {32'h0, ID}, ONES);
    shift_ir_seq("ir_idcode", 4'b0010);
    shift_dr_seq("idcode_delay", 40, 64'hA5, {24'h0, 8'hA5, ID}, 64'h0);
    shift_ir_seq("ir_debug", 4'b1000);
    chk("debug_dsel", dsel, 1);
    shift_dr_seq("debug", 8, 64'h3C, 64'h69, 64'h69);
    shift_ir_seq("ir_0111", 4'b0111);
    chk("unknown_dsel", dsel, 0);
    shift_dr_seq("unknown_bypass", 4, 64'hD, 64'hA, ONES);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    expect_bit("pause_bypass", 0, 1'b0);
    step(1, 0);
    step(0, 0);
    chk("pause_decodes", {shift_dr, pause_dr, update_dr, capture_dr}, 4'b0100);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    expect_bit("abort_ir", 0, 1'b1);
    step(0, 1);
    expect_bit("abort_ir", 1, 1'b0);
    step(0, 1);
    trstn = 1'b0;
    #1;
    chk("abort_oe", tdo_oe, 0);
    chk("abort_decodes", {shift_dr, pause_dr, update_dr, capture_dr}, 0);
    chk("abort_dsel", dsel, 0);
    @(posedge tck);
    #2 trstn = 1'b1;
    step(0, 0);
    shift_dr_seq("idcode_after_abort", 32, 64'h0, {32'h0, ID}, ONES);
    repeat (3) @(posedge tck);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
